// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    StBoot,
    StRun
  } fetch_state_e;

  localparam logic [3:0]  COND_AL     = 4'hE;
  localparam logic [2:0]  OPC_BRANCH  = 3'b101;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] PIPE_OFFSET = 32'd8;

  // ARM B/BL target: PC reads as the instruction address plus 8, offset is in words.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] inst);
    return pc + PIPE_OFFSET + {{6{inst[23]}}, inst[23:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_branch_detect.sv
// Recognises unconditional B/BL words and computes their target.
module fetch_branch_detect
  import fetch_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        is_uncond_branch,
  output logic [31:0] target
);

  // Condition must be AL; conditional branches stay with execute.
  always_comb begin
    is_uncond_branch = (inst[31:28] == COND_AL) && (inst[27:25] == OPC_BRANCH);
    target           = branch_target(pc, inst);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a synchronous ROM.
// Optional early folding of unconditional branches: define FETCH_EARLY_BRANCH_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_pc,
  input  logic [31:0] rom_inst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q;
  logic [31:0]  fetch_count_q;
  logic         br_hit;
  logic [31:0]  br_target;

`ifdef FETCH_EARLY_BRANCH_EN
  fetch_branch_detect u_branch_detect (
    .inst             (rom_inst),
    .pc               (req_pc_q),
    .is_uncond_branch (br_hit),
    .target           (br_target)
  );
`else
  assign br_hit    = 1'b0;
  assign br_target = '0;
`endif

  // Next fetch address in priority order, state advance and decode-facing outputs.
  always_comb begin
    state_d        = state_q;
    rom_pc         = RESET_PC;
    out_valid      = 1'b0;
    out_pred_taken = 1'b0;
    out_inst       = rom_inst;
    out_pc         = req_pc_q;

    out_valid      = (state_q == StRun) && !redirect_valid;
    out_pred_taken = out_valid && !stall && br_hit;

    if (redirect_valid) begin
      // Low address bits are forced to zero so the ROM always sees word addresses.
      rom_pc  = redirect_pc & ~32'h3;
      state_d = StRun;
    end else if (state_q == StBoot) begin
      rom_pc  = RESET_PC;
      state_d = StRun;
    end else if (stall) begin
      // Re-fetching the same word keeps the ROM output stable across the stall.
      rom_pc = req_pc_q;
    end else if (out_pred_taken) begin
      rom_pc = br_target;
    end else begin
      rom_pc = req_pc_q + PC_STEP;
    end
  end

  // State, requested address and accepted-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StBoot;
      req_pc_q      <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= rom_pc;
      if (out_valid && !stall) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a ROM model and an instruction-stream reference.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] rom_pc;
  logic [31:0] rom_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] fetch_count;

  int errors;
  int checks;

`ifdef FETCH_EARLY_BRANCH_EN
  localparam bit Fold = 1'b1;
`else
  localparam bit Fold = 1'b0;
`endif

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_pc         (rom_pc),
    .rom_inst       (rom_inst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pred_taken (out_pred_taken),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: a short program plus address-derived filler that never decodes as a branch.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_2005;
      32'h0000_0004: return 32'hE3A0_3008;
      32'h0000_0008: return 32'hE083_4005;
      32'h0000_000C: return 32'hEA00_002A;  // B +0x2A words
      32'h0000_0100: return 32'hEAFF_FFFE;  // B to itself
      32'h0000_0200: return 32'hEBFF_FF80;  // BL back to 0x8
      32'h0000_0204: return 32'h0A00_0010;  // BEQ, never folded
      default:       return 32'hE3A0_0000 | {16'h0, a[17:2]};
    endcase
  endfunction

  // Would the word at this address be folded at fetch?
  function automatic bit model_folds(input logic [31:0] a);
    bit hit;
    hit = 1'b0;
`ifdef FETCH_EARLY_BRANCH_EN
    begin
      logic [31:0] w;
      w   = rom_word(a);
      hit = (w[31:28] == 4'hE) && (w[27:25] == 3'b101);
    end
`endif
    return hit;
  endfunction

  // Address of the instruction that follows an accepted instruction at a.
  function automatic logic [31:0] model_next(input logic [31:0] a);
    logic [31:0] n;
    n = a + 32'd4;
`ifdef FETCH_EARLY_BRANCH_EN
    if (model_folds(a)) begin
      logic [31:0] w;
      int off;
      w   = rom_word(a);
      off = int'(w[23:0]);
      if (off >= (1 << 23)) off = off - (1 << 24);
      n = a + 32'd8 + 32'(off * 4);
    end
`endif
    return n;
  endfunction

  // Synchronous ROM with one cycle of latency, zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rom_inst <= '0;
    else     rom_inst <= rom_word(rom_pc);
  end

  // Reference: which address decode sees next and how many were accepted.
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started <= 1'b0;
      m_pc      <= 32'h0;
      m_count   <= 32'h0;
    end else begin
      if (m_started && !redirect_valid && !stall) m_count <= m_count + 32'd1;
      m_started <= 1'b1;
      if (redirect_valid)  m_pc <= {redirect_pc[31:2], 2'b00};
      else if (!m_started) m_pc <= 32'h0;
      else if (!stall)     m_pc <= model_next(m_pc);
    end
  end

  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = t;
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (fetch_count !== 32'h0) begin
      errors++; $display("FAIL reset_count: got %h want 0", fetch_count);
    end
    checks++;
    if (rom_pc !== 32'h0) begin
      errors++; $display("FAIL reset_rom_pc: got %h want 0", rom_pc);
    end
    checks++;
    if (out_pc !== 32'h0) begin
      errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc);
    end
    checks++;
    if (out_pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_pred: got %b want 0", out_pred_taken);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] pcs   [3];
    logic [31:0] words [3];
    pcs   = '{32'h0, 32'h4, 32'h8};
    words = '{32'hE3A0_2005, 32'hE3A0_3008, 32'hE083_4005};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_inst !== words[i]) begin
        errors++;
        $display("FAIL seq_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, pcs[i], words[i]);
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (fetch_count !== 32'd3) begin
      errors++; $display("FAIL seq_count: got %0d want 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'hE3A0_3008) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h want v=1 pc=4 inst=e3a03008",
                 i, out_valid, out_pc, out_inst);
      end
      checks++;
      if (fetch_count !== 32'd1) begin
        errors++; $display("FAIL stall_count_%0d: got %0d want 1", i, fetch_count);
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_pc !== 32'h4) begin
      errors++; $display("FAIL stall_release: got pc=%h want 4", out_pc);
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL stall_after: got v=%b pc=%h cnt=%0d want v=1 pc=8 cnt=2",
               out_valid, out_pc, fetch_count);
    end
  endtask

  task automatic test_redirect(input logic with_stall);
    do_reset();
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    // Unaligned target checks that the low bits are dropped.
    drive(with_stall, 1'b1, with_stall ? 32'h0000_0043 : 32'h0000_0040);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_squash(stall=%b): got v=%b want 0", with_stall, out_valid);
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== rom_word(32'h40)) begin
      errors++;
      $display("FAIL redir_target(stall=%b): got v=%b pc=%h inst=%h want v=1 pc=40 inst=%h",
               with_stall, out_valid, out_pc, out_inst, rom_word(32'h40));
    end
    checks++;
    if (fetch_count !== 32'd2) begin
      errors++; $display("FAIL redir_count(stall=%b): got %0d want 2", with_stall, fetch_count);
    end
  endtask

  task automatic test_branch();
    logic [31:0] want_pc;
    want_pc = Fold ? 32'h0000_00BC : 32'h0000_0010;
    do_reset();
    repeat (4) drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_pc !== 32'hC || out_inst !== 32'hEA00_002A || out_pred_taken !== Fold) begin
      errors++;
      $display("FAIL branch_pred: got pc=%h inst=%h pred=%b want pc=c inst=ea00002a pred=%b",
               out_pc, out_inst, out_pred_taken, Fold);
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== want_pc) begin
      errors++;
      $display("FAIL branch_next: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, want_pc);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (3) drive(1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rom_pc !== 32'h0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL midrst: got v=%b rom_pc=%h cnt=%0d want v=0 rom_pc=0 cnt=0",
               out_valid, rom_pc, fetch_count);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'hE3A0_2005) begin
      errors++;
      $display("FAIL midrst_restart: got v=%b pc=%h inst=%h want v=1 pc=0 inst=e3a02005",
               out_valid, out_pc, out_inst);
    end
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_pc !== 32'h8 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL midrst_seq: got pc=%h cnt=%0d want pc=8 cnt=2", out_pc, fetch_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_pc !== 32'hFFFF_FFFC || rom_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_rom_pc: got pc=%h rom_pc=%h want pc=fffffffc rom_pc=0", out_pc, rom_pc);
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    logic        s, r;
    logic [31:0] t;
    bit          exp_valid, exp_pred;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       t = 32'h0000_000C;
        1:       t = 32'h0000_0100;
        2:       t = 32'h0000_0200;
        3:       t = 32'h0000_0204;
        4:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: t = $urandom;
      endcase
      drive(s, r, t);
      exp_valid = m_started && !r;
      exp_pred  = exp_valid && !s && model_folds(m_pc);
      checks++;
      if (out_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (out_pc !== m_pc || out_inst !== rom_word(m_pc) || out_pred_taken !== exp_pred) begin
          errors++;
          $display("FAIL rand_word[%0d]: got pc=%h inst=%h pred=%b want pc=%h inst=%h pred=%b",
                   n, out_pc, out_inst, out_pred_taken, m_pc, rom_word(m_pc), exp_pred);
        end
      end
      checks++;
      if (fetch_count !== m_count) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, fetch_count, m_count);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_branch();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
